sequential_divider: RTL and testbench

- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the team's combinational add/subtract arithmetic circuit.
- It reuses a single subtract-and-compare step, iterated once per clock, one quotient bit per cycle.
- It sits beside the arithmetic circuit in the datapath and is driven by a controller through a START/BUSY/DONE handshake.

---
 rtl/sequential_divider.sv | 139 +++++++++++++
 tb/tb_sequential_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider with a START/BUSY/DONE handshake.
// Each clock performs one shift/subtract-compare step and yields one quotient bit.
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [CW-1:0]    cnt_r;

    logic             accept_s;
    logic             last_s;
    logic             zero_div_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             trial_ok_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dvd_next_s;

    assign zero_div_s = (B == {WIDTH{1'b0}});
    assign last_s     = (cnt_r == CW'(WIDTH - 1));

    // One restoring step; the partial remainder is held in WIDTH bits because
    // it is always below the divisor, the extra bit only exists in the trial.
    always_comb begin
        shifted_s  = {rem_r, dvd_r[WIDTH-1]};
        trial_s    = shifted_s - {1'b0, dvs_r};
        trial_ok_s = ~trial_s[WIDTH];
        if (trial_ok_s) begin
            rem_next_s = trial_s[WIDTH-1:0];
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
        dvd_next_s = {dvd_r[WIDTH-2:0], trial_ok_s};
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; IDLE and DONE both accept a new request.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    accept_s     = 1'b1;
                    state_next_s = zero_div_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Working registers and registered results.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dvd_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            Q        <= {WIDTH{1'b0}};
            R        <= {WIDTH{1'b0}};
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DIV_ZERO <= 1'b0;
        end else if (accept_s) begin
            dvd_r <= A;
            dvs_r <= B;
            rem_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            if (zero_div_s) begin
                Q        <= {WIDTH{1'b1}};
                R        <= A;
                DIV_ZERO <= 1'b1;
                DONE     <= 1'b1;
                BUSY     <= 1'b0;
            end else begin
                DONE <= 1'b0;
                BUSY <= 1'b1;
            end
        end else if (state_r == ST_RUN) begin
            dvd_r <= dvd_next_s;
            rem_r <= rem_next_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
                Q        <= dvd_next_s;
                R        <= rem_next_s;
                DIV_ZERO <= 1'b0;
                DONE     <= 1'b1;
                BUSY     <= 1'b0;
            end else begin
                DONE <= 1'b0;
            end
        end else begin
            DONE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (WIDTH=4): handshake timing, results,
// divide-by-zero, ignored START, asynchronous abort and a back-to-back sweep.
module tb_sequential_divider;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q;
    logic [3:0] R;
    logic       BUSY;
    logic       DONE;
    logic       DIV_ZERO;

    int checks = 0;
    int errors = 0;
    int last_q = 0;
    int last_r = 0;

    sequential_divider #(.WIDTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DIV_ZERO (DIV_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request with START for a single edge, then follow it to DONE.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input int exp_q, input int exp_r, input int exp_dz, input bit glitch);
        int e;
        A = a;
        B = b;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        e = 0;
        while (DONE !== 1'b1 && e < 20) begin
            chk({tag, "_busy"}, 32'(BUSY), 32'd1);
            chk({tag, "_qhold"}, 32'(Q), 32'(last_q));
            chk({tag, "_rhold"}, 32'(R), 32'(last_r));
            if (glitch && e == 1) begin
                START = 1'b1;
                A = 4'd1;
                B = 4'd1;
            end else if (glitch && e == 2) begin
                START = 1'b0;
            end
            @(negedge CLK);
            e++;
        end
        chk({tag, "_latency"}, 32'(e), (b == 4'd0) ? 32'd0 : 32'd4);
        chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
        chk({tag, "_q"}, 32'(Q), 32'(exp_q));
        chk({tag, "_r"}, 32'(R), 32'(exp_r));
        chk({tag, "_dz"}, 32'(DIV_ZERO), 32'(exp_dz));
        last_q = exp_q;
        last_r = exp_r;
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        chk({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int e;
        int ndone;
        int ia;
        int ib;

        RST = 1'b1;
        START = 1'b0;
        A = 4'd0;
        B = 4'd0;
        @(negedge CLK);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_dz", 32'(DIV_ZERO), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_op("d13_3", 4'd13, 4'd3, 4, 1, 0, 1'b0);
        run_op("d15_1", 4'd15, 4'd1, 15, 0, 0, 1'b0);
        run_op("d2_5", 4'd2, 4'd5, 0, 2, 0, 1'b0);
        run_op("d0_7", 4'd0, 4'd7, 0, 0, 0, 1'b0);
        run_op("d9_0", 4'd9, 4'd0, 15, 9, 1, 1'b0);
        run_op("d6_2", 4'd6, 4'd2, 3, 0, 0, 1'b0);
        run_op("d14_4_glitch", 4'd14, 4'd4, 3, 2, 0, 1'b1);

        // Asynchronous abort between edges 2 and 3 of a running operation.
        A = 4'd11;
        B = 4'd2;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_q", 32'(Q), 32'd0);
        chk("abort_r", 32'(R), 32'd0);
        chk("abort_dz", 32'(DIV_ZERO), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        last_q = 0;
        last_r = 0;
        run_op("d11_2", 4'd11, 4'd2, 5, 1, 0, 1'b0);

        // Back-to-back sweep with START held high; next operands go in once DONE is seen.
        START = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ia = i / 16;
            ib = i % 16;
            A = 4'(ia);
            B = 4'(ib);
            @(negedge CLK);
            e = 0;
            while (DONE !== 1'b1 && e < 20) begin
                @(negedge CLK);
                e++;
            end
            chk("sweep_latency", 32'(e), (ib == 0) ? 32'd0 : 32'd4);
            chk("sweep_q", 32'(Q), (ib == 0) ? 32'd15 : 32'(ia / ib));
            chk("sweep_r", 32'(R), (ib == 0) ? 32'(ia) : 32'(ia % ib));
            chk("sweep_dz", 32'(DIV_ZERO), (ib == 0) ? 32'd1 : 32'd0);
        end
        START = 1'b0;
        @(negedge CLK);
        chk("sweep_end_done", 32'(DONE), 32'd0);
        chk("sweep_end_busy", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
